// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared tile geometry, tile type and reader FSM states
// Default widths and tile shape used by the tile reader and its buffer.
// tile_t: element [i][j] is row i, column j of an M x N tile.
// rd_state_e: IDLE (accepting commands), ISSUE (reads going out), DRAIN (waiting for last tile).
package gemm_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int M_DEF          = 4;
  localparam int N_DEF          = 4;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef logic [M_DEF-1:0][N_DEF-1:0][DATA_WIDTH_DEF-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/tile_fifo2.sv
// rtl/tile_fifo2.sv - 2-entry first-word-fall-through tile buffer
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, push_data write one entry (never while full)
//   pop             consume the head entry (ignored when empty)
//   pop_data        head entry, visible while !empty; zero when empty
//   full, empty     status flags
//   occupancy       number of stored entries (0..2)
module tile_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign occupancy = count_q;
  assign do_pop    = pop && !empty;
  assign pop_data  = empty ? '0 : slot_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The reader's credit check guarantees a push never lands on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/sram_tile_reader.sv
// rtl/sram_tile_reader.sv - tile-burst read initiator for the tile SRAM
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_base/cmd_stride/cmd_count   first tile address, address step, tile count
//   sram_grant                      arbiter allows a read this cycle
//   sram_read_enable/write_enable   SRAM strobes (write tied low)
//   sram_address/sram_data          tile address out, tile data back one cycle later
//   tile_valid/tile_ready           output tile handshake
//   tile_data/tile_last             output tile and end-of-command marker
//   done                            one-cycle completion pulse
module sram_tile_reader
  import gemm_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int M          = M_DEF,
  parameter int N          = N_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                cmd_base,
  input  logic [ADDR_WIDTH-1:0]                cmd_stride,
  input  logic [CNT_WIDTH-1:0]                 cmd_count,
  input  logic                                 sram_grant,
  output logic                                 sram_read_enable,
  output logic                                 sram_write_enable,
  output logic [ADDR_WIDTH-1:0]                sram_address,
  input  logic [M-1:0][N-1:0][DATA_WIDTH-1:0]  sram_data,
  output logic                                 tile_valid,
  input  logic                                 tile_ready,
  output logic [M-1:0][N-1:0][DATA_WIDTH-1:0]  tile_data,
  output logic                                 tile_last,
  output logic                                 done
);

  localparam int TILE_BITS = M * N * DATA_WIDTH;
  localparam int ENTRY_BITS = TILE_BITS + 1;

  rd_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  stride_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [CNT_WIDTH-1:0]   issued_q;
  logic                   pending_q;
  logic                   pending_last_q;
  logic                   zero_done_q;

  logic                   cmd_fire;
  logic                   pop;
  logic                   issue;
  logic                   last_issue;
  logic [2:0]             in_use;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [1:0]             fifo_occ;
  logic [ENTRY_BITS-1:0]  fifo_out;

  assign cmd_ready         = (state_q == IDLE) && !reset;
  assign cmd_fire          = cmd_valid && cmd_ready;
  assign pop               = tile_valid && tile_ready;
  assign sram_write_enable = 1'b0;
  assign sram_address      = addr_q;

  // Slots spoken for: stored tiles plus the read in flight. A pop this cycle
  // frees its slot in time for a new read, which sustains 1 tile/clk.
  assign in_use     = 3'(fifo_occ) + 3'(pending_q) - 3'(pop);
  assign issue      = (state_q == ISSUE) && sram_grant && (in_use < 3'd2);
  assign last_issue = issue && (issued_q == count_q - CNT_WIDTH'(1));

  assign sram_read_enable = issue;

  always_comb begin
    state_d = state_q;
    done    = zero_done_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire && (cmd_count != '0)) state_d = ISSUE;
      end
      ISSUE: begin
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && tile_last) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      stride_q       <= '0;
      count_q        <= '0;
      issued_q       <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      zero_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      zero_done_q    <= cmd_fire && (cmd_count == '0);
      pending_q      <= issue;
      pending_last_q <= last_issue;
      if (cmd_fire) begin
        addr_q   <= cmd_base;
        stride_q <= cmd_stride;
        count_q  <= cmd_count;
        issued_q <= '0;
      end else if (issue) begin
        // Running sum replaces base + issued*stride; wraps naturally.
        addr_q   <= addr_q + stride_q;
        issued_q <= issued_q + CNT_WIDTH'(1);
      end
    end
  end

  tile_fifo2 #(
    .WIDTH(ENTRY_BITS)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (pending_q),
    .push_data ({pending_last_q, sram_data}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign tile_valid = !fifo_empty;
  assign tile_last  = fifo_out[ENTRY_BITS-1];
  assign tile_data  = fifo_out[TILE_BITS-1:0];

endmodule
